// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection sequencer: state encoding,
// signal-head aspects and default phase timings.
package traffic_pkg;

  typedef enum logic [3:0] {
    NS_LEFT    = 4'd0,
    NS_GREEN   = 4'd1,
    NS_YELLOW  = 4'd2,
    ALL_RED_NS = 4'd3,
    EW_LEFT    = 4'd4,
    EW_GREEN   = 4'd5,
    EW_YELLOW  = 4'd6,
    ALL_RED_EW = 4'd7,
    ALL_STOP   = 4'd8
  } state_e;

  // Direction that held right-of-way when a preemption was accepted.
  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_e;

  // Head encoding {left, green, yellow, red}; the protected left keeps red lit.
  localparam logic [3:0] LIGHT_LEFT   = 4'b1001;
  localparam logic [3:0] LIGHT_GREEN  = 4'b0100;
  localparam logic [3:0] LIGHT_YELLOW = 4'b0010;
  localparam logic [3:0] LIGHT_RED    = 4'b0001;

  localparam int LEFT_T_DEF   = 5;
  localparam int GREEN_T_DEF  = 10;
  localparam int YELLOW_T_DEF = 3;
  localparam int ALLRED_T_DEF = 2;
  localparam int CW_DEF       = 5;

endpackage

// File: rtl/intersection_controller_phase_timer.sv
// Phase timer: counts cycles in the current state against a loaded duration.
// In saturate mode the count parks at dur-1 instead of restarting.
module phase_timer #(
  parameter int CW = 5
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          sat,
  input  logic [CW-1:0] dur,
  output logic          done
);

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] cnt_q, cnt_d;

  assign done = (cnt_q >= (dur - ONE));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (done) begin
      cnt_d = sat ? cnt_q : '0;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/intersection_controller.sv
// Four-way intersection sequencer with all-red clearance and emergency stop.
// Optional macro LEFT_SENSE_EN adds left-turn demand inputs that can skip LEFT phases.
module intersection_controller
  import traffic_pkg::*;
#(
  parameter int LEFT_T   = LEFT_T_DEF,
  parameter int GREEN_T  = GREEN_T_DEF,
  parameter int YELLOW_T = YELLOW_T_DEF,
  parameter int ALLRED_T = ALLRED_T_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       emergency,
`ifdef LEFT_SENSE_EN
  input  logic       left_req_ns,
  input  logic       left_req_ew,
`endif
  output logic [3:0] ns_out,
  output logic [3:0] ew_out,
  output logic [3:0] phase,
  output logic       emergency_ack
);

  localparam logic [CW-1:0] LEFT_D   = LEFT_T[CW-1:0];
  localparam logic [CW-1:0] GREEN_D  = GREEN_T[CW-1:0];
  localparam logic [CW-1:0] YELLOW_D = YELLOW_T[CW-1:0];
  localparam logic [CW-1:0] ALLRED_D = ALLRED_T[CW-1:0];

  state_e state_q, state_d;
  state_e ns_entry, ew_entry;
  dir_e   last_dir_q, last_dir_d;
  logic   pend_stop_q, pend_stop_d;
  logic   done;

  function automatic logic [CW-1:0] dur_of(state_e s);
    case (s)
      NS_LEFT, EW_LEFT:     dur_of = LEFT_D;
      NS_GREEN, EW_GREEN:   dur_of = GREEN_D;
      NS_YELLOW, EW_YELLOW: dur_of = YELLOW_D;
      default:              dur_of = ALLRED_D;
    endcase
  endfunction

  phase_timer #(.CW(CW)) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state_d != state_q),
    .sat     (state_q == ALL_STOP),
    .dur     (dur_of(state_q)),
    .done    (done)
  );

`ifdef LEFT_SENSE_EN
  logic lreq_ns_q, lreq_ns_d;
  logic lreq_ew_q, lreq_ew_d;

  assign ns_entry = lreq_ns_q ? NS_LEFT : NS_GREEN;
  assign ew_entry = lreq_ew_q ? EW_LEFT : EW_GREEN;

  // Demand is sticky until the direction is next granted right-of-way.
  always_comb begin
    lreq_ns_d = lreq_ns_q | left_req_ns;
    lreq_ew_d = lreq_ew_q | left_req_ew;
    if ((state_d != state_q) && (state_d == NS_LEFT || state_d == NS_GREEN)) begin
      lreq_ns_d = 1'b0;
    end
    if ((state_d != state_q) && (state_d == EW_LEFT || state_d == EW_GREEN)) begin
      lreq_ew_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lreq_ns_q <= 1'b0;
      lreq_ew_q <= 1'b0;
    end else begin
      lreq_ns_q <= lreq_ns_d;
      lreq_ew_q <= lreq_ew_d;
    end
  end
`else
  assign ns_entry = NS_LEFT;
  assign ew_entry = EW_LEFT;
`endif

  always_comb begin
    state_d     = state_q;
    pend_stop_d = pend_stop_q;
    last_dir_d  = last_dir_q;
    case (state_q)
      NS_LEFT, NS_GREEN: begin
        if (emergency) begin
          state_d     = NS_YELLOW;
          pend_stop_d = 1'b1;
          last_dir_d  = DIR_NS;
        end else if (done) begin
          state_d = (state_q == NS_LEFT) ? NS_GREEN : NS_YELLOW;
        end
      end
      NS_YELLOW: begin
        if (emergency) begin
          pend_stop_d = 1'b1;
          last_dir_d  = DIR_NS;
        end
        if (done) begin
          state_d = (pend_stop_q || emergency) ? ALL_STOP : ALL_RED_NS;
        end
      end
      ALL_RED_NS: begin
        if (emergency) begin
          state_d    = ALL_STOP;
          last_dir_d = DIR_NS;
        end else if (done) begin
          state_d = ew_entry;
        end
      end
      EW_LEFT, EW_GREEN: begin
        if (emergency) begin
          state_d     = EW_YELLOW;
          pend_stop_d = 1'b1;
          last_dir_d  = DIR_EW;
        end else if (done) begin
          state_d = (state_q == EW_LEFT) ? EW_GREEN : EW_YELLOW;
        end
      end
      EW_YELLOW: begin
        if (emergency) begin
          pend_stop_d = 1'b1;
          last_dir_d  = DIR_EW;
        end
        if (done) begin
          state_d = (pend_stop_q || emergency) ? ALL_STOP : ALL_RED_EW;
        end
      end
      ALL_RED_EW: begin
        // This clearance follows EW service, so EW counts as the served side.
        if (emergency) begin
          state_d    = ALL_STOP;
          last_dir_d = DIR_EW;
        end else if (done) begin
          state_d = ns_entry;
        end
      end
      ALL_STOP: begin
        pend_stop_d = 1'b0;
        if (done && !emergency) begin
          state_d = (last_dir_q == DIR_NS) ? ew_entry : ns_entry;
        end
      end
      default: begin
        state_d = ALL_RED_EW;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ALL_RED_EW;
      pend_stop_q <= 1'b0;
      last_dir_q  <= DIR_NS;
    end else begin
      state_q     <= state_d;
      pend_stop_q <= pend_stop_d;
      last_dir_q  <= last_dir_d;
    end
  end

  // Moore decode: heads depend on the state register alone.
  always_comb begin
    ns_out        = LIGHT_RED;
    ew_out        = LIGHT_RED;
    emergency_ack = 1'b0;
    case (state_q)
      NS_LEFT:   ns_out = LIGHT_LEFT;
      NS_GREEN:  ns_out = LIGHT_GREEN;
      NS_YELLOW: ns_out = LIGHT_YELLOW;
      EW_LEFT:   ew_out = LIGHT_LEFT;
      EW_GREEN:  ew_out = LIGHT_GREEN;
      EW_YELLOW: ew_out = LIGHT_YELLOW;
      ALL_STOP:  emergency_ack = 1'b1;
      default:   ;
    endcase
  end

  assign phase = state_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Bench for intersection_controller: segment tables expanded into a per-cycle
// scoreboard, plus hand-written reset sequences and a safety assertion.
module tb_intersection_controller;
  import traffic_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       emergency = 1'b0;
  logic [3:0] ns_out, ew_out, phase;
  logic       emergency_ack;
`ifdef LEFT_SENSE_EN
  logic       left_req_ns = 1'b1;
  logic       left_req_ew = 1'b1;
`endif

  intersection_controller dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .emergency     (emergency),
`ifdef LEFT_SENSE_EN
    .left_req_ns   (left_req_ns),
    .left_req_ew   (left_req_ew),
`endif
    .ns_out        (ns_out),
    .ew_out        (ew_out),
    .phase         (phase),
    .emergency_ack (emergency_ack)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] ns;
    logic [3:0] ew;
    logic       ack;
  } exp_t;

  typedef struct {
    int         len;
    logic [3:0] ns;
    logic [3:0] ew;
    logic       ack;
  } seg_t;

  seg_t         segs[$];
  exp_t         sb[$];
  logic [127:0] emg_mask;
  int           total = 0;
  int           bad = 0;

  a_safe: assert property (@(posedge clock) disable iff (!reset_n)
                           (ns_out == LIGHT_RED) || (ew_out == LIGHT_RED))
    else begin
      bad++;
      $display("FAIL safety ns=%b ew=%b", ns_out, ew_out);
    end

  task automatic check(input string name, input int cyc, input logic [3:0] act,
                       input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%b want=%b", name, cyc, act, req);
    end
  endtask

  task automatic add_seg(input int len, input logic [3:0] ns, input logic [3:0] ew,
                         input logic ack);
    seg_t s;
    s.len = len; s.ns = ns; s.ew = ew; s.ack = ack;
    segs.push_back(s);
  endtask

  task automatic add_normal(input int periods);
    for (int p = 0; p < periods; p++) begin
      add_seg(2,  LIGHT_RED,    LIGHT_RED,    1'b0);
      add_seg(5,  LIGHT_LEFT,   LIGHT_RED,    1'b0);
      add_seg(10, LIGHT_GREEN,  LIGHT_RED,    1'b0);
      add_seg(3,  LIGHT_YELLOW, LIGHT_RED,    1'b0);
      add_seg(2,  LIGHT_RED,    LIGHT_RED,    1'b0);
      add_seg(5,  LIGHT_RED,    LIGHT_LEFT,   1'b0);
      add_seg(10, LIGHT_RED,    LIGHT_GREEN,  1'b0);
      add_seg(3,  LIGHT_RED,    LIGHT_YELLOW, 1'b0);
    end
  endtask

  // Asserts reset asynchronously, checks the reset aspects before any edge,
  // then releases on a falling edge; that cycle is cycle 0 of the next run.
  task automatic do_reset(input string name);
    logic [3:0] want_phase;
    want_phase = ALL_RED_EW;
    reset_n = 1'b0;
    emergency = 1'b0;
    #1;
    check({name, "_rst_ns"},    0, ns_out, LIGHT_RED);
    check({name, "_rst_ew"},    0, ew_out, LIGHT_RED);
    check({name, "_rst_ack"},   0, {3'b000, emergency_ack}, 4'b0000);
    check({name, "_rst_phase"}, 0, phase, want_phase);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic run_scn(input string name, input int ncyc);
    exp_t e;
    int   k;
    k = 0;
    foreach (segs[i]) begin
      for (int j = 0; j < segs[i].len; j++) begin
        if (k < ncyc) begin
          emergency = emg_mask[k];
          e.ns = segs[i].ns; e.ew = segs[i].ew; e.ack = segs[i].ack;
          sb.push_back(e);
          #1;
          e = sb.pop_front();
          check({name, "_ns"},  k, ns_out, e.ns);
          check({name, "_ew"},  k, ew_out, e.ew);
          check({name, "_ack"}, k, {3'b000, emergency_ack}, {3'b000, e.ack});
          @(negedge clock);
        end
        k++;
      end
    end
    emergency = 1'b0;
    segs.delete();
  endtask

  initial begin
    #1;

    do_reset("normal");
    emg_mask = '0;
    add_normal(2);
    run_scn("normal", 80);

    do_reset("pulse");
    emg_mask = '0;
    emg_mask[10] = 1'b1;
    add_seg(2,  LIGHT_RED,    LIGHT_RED,    1'b0);
    add_seg(5,  LIGHT_LEFT,   LIGHT_RED,    1'b0);
    add_seg(4,  LIGHT_GREEN,  LIGHT_RED,    1'b0);
    add_seg(3,  LIGHT_YELLOW, LIGHT_RED,    1'b0);
    add_seg(2,  LIGHT_RED,    LIGHT_RED,    1'b1);
    add_seg(5,  LIGHT_RED,    LIGHT_LEFT,   1'b0);
    add_seg(10, LIGHT_RED,    LIGHT_GREEN,  1'b0);
    add_seg(3,  LIGHT_RED,    LIGHT_YELLOW, 1'b0);
    add_seg(2,  LIGHT_RED,    LIGHT_RED,    1'b0);
    add_seg(5,  LIGHT_LEFT,   LIGHT_RED,    1'b0);
    run_scn("pulse", 41);

    do_reset("held");
    emg_mask = '0;
    for (int i = 22; i <= 41; i++) emg_mask[i] = 1'b1;
    add_seg(2,  LIGHT_RED,    LIGHT_RED,    1'b0);
    add_seg(5,  LIGHT_LEFT,   LIGHT_RED,    1'b0);
    add_seg(10, LIGHT_GREEN,  LIGHT_RED,    1'b0);
    add_seg(3,  LIGHT_YELLOW, LIGHT_RED,    1'b0);
    add_seg(2,  LIGHT_RED,    LIGHT_RED,    1'b0);
    add_seg(1,  LIGHT_RED,    LIGHT_LEFT,   1'b0);
    add_seg(3,  LIGHT_RED,    LIGHT_YELLOW, 1'b0);
    add_seg(17, LIGHT_RED,    LIGHT_RED,    1'b1);
    add_seg(5,  LIGHT_LEFT,   LIGHT_RED,    1'b0);
    add_seg(10, LIGHT_GREEN,  LIGHT_RED,    1'b0);
    run_scn("held", 58);

    // Request in ALL_RED_NS, then re-request on the would-be exit edge.
    do_reset("allred");
    emg_mask = '0;
    emg_mask[20] = 1'b1;
    emg_mask[22] = 1'b1;
    add_seg(2,  LIGHT_RED,    LIGHT_RED,    1'b0);
    add_seg(5,  LIGHT_LEFT,   LIGHT_RED,    1'b0);
    add_seg(10, LIGHT_GREEN,  LIGHT_RED,    1'b0);
    add_seg(3,  LIGHT_YELLOW, LIGHT_RED,    1'b0);
    add_seg(1,  LIGHT_RED,    LIGHT_RED,    1'b0);
    add_seg(3,  LIGHT_RED,    LIGHT_RED,    1'b1);
    add_seg(5,  LIGHT_RED,    LIGHT_LEFT,   1'b0);
    add_seg(10, LIGHT_RED,    LIGHT_GREEN,  1'b0);
    run_scn("allred", 39);

    // Asynchronous reset in the middle of NS_GREEN, between clock edges.
    do_reset("midrst_a");
    emg_mask = '0;
    add_normal(1);
    run_scn("midrst_pre", 12);
    #1;
    check("midrst_green_before", 12, ns_out, LIGHT_GREEN);
    #1;
    do_reset("midrst_b");
    emg_mask = '0;
    add_normal(1);
    run_scn("midrst_post", 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
